// File: rtl/overlay_v1_0_logo_split.sv
// Splits a packed alpha+colour logo stream into separate logo and alpha
// AXI-Stream channels, regenerating TLAST from the programmed geometry.

module overlay_v1_0_logo_split_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         din_last,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dout_last,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic [1:0]   last_mem;
  logic         wr_ptr;
  logic         rd_ptr;

  // Two-entry ring; the producer never pushes when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      last_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]      <= din;
        last_mem[wr_ptr] <= din_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout      = mem[rd_ptr];
  assign dout_last = last_mem[rd_ptr];

endmodule

module overlay_v1_0_logo_split #(
  parameter int unsigned S_AXI_CTRL_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned ALPHA_WIDTH           = 8
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             reset,
  input  logic                             run,
  input  logic [S_AXI_CTRL_DATA_WIDTH-1:0] logo_width,
  input  logic [S_AXI_CTRL_DATA_WIDTH-1:0] logo_height,
  output logic                             done,
  output logic                             frame_error,
  output logic [S_AXI_CTRL_DATA_WIDTH-1:0] hcount,
  output logic [S_AXI_CTRL_DATA_WIDTH-1:0] vcount,
  input  logic [DATA_WIDTH+ALPHA_WIDTH-1:0] S_AXIS_TDATA_ARGB,
  input  logic                             S_AXIS_TVALID_ARGB,
  output logic                             S_AXIS_TREADY_ARGB,
  input  logic                             S_AXIS_TLAST_ARGB,
  output logic [DATA_WIDTH-1:0]            M_AXIS_TDATA_LOGO,
  output logic                             M_AXIS_TVALID_LOGO,
  input  logic                             M_AXIS_TREADY_LOGO,
  output logic                             M_AXIS_TLAST_LOGO,
  output logic [ALPHA_WIDTH-1:0]           M_AXIS_TDATA_ALPHA,
  output logic                             M_AXIS_TVALID_ALPHA,
  input  logic                             M_AXIS_TREADY_ALPHA,
  output logic                             M_AXIS_TLAST_ALPHA
);

  localparam int unsigned CW = S_AXI_CTRL_DATA_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ALPHA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] w_m1;
  logic [CW-1:0] h_m1;
  logic [1:0]    logo_cnt;
  logic [1:0]    alpha_cnt;
  logic          accept;
  logic          last_pix;
  logic          logo_pop;
  logic          alpha_pop;
  logic          logo_drained;
  logic          alpha_drained;
  logic          zero_size;

  assign S_AXIS_TREADY_ARGB = (state == ST_STREAM) && run &&
                              (logo_cnt < 2'd2) && (alpha_cnt < 2'd2);
  assign accept    = S_AXIS_TVALID_ARGB && S_AXIS_TREADY_ARGB;
  assign last_pix  = (hcount == w_m1) && (vcount == h_m1);
  assign zero_size = (logo_width == '0) || (logo_height == '0);

  assign M_AXIS_TVALID_LOGO  = (logo_cnt != 2'd0);
  assign M_AXIS_TVALID_ALPHA = (alpha_cnt != 2'd0);
  assign logo_pop  = M_AXIS_TVALID_LOGO && M_AXIS_TREADY_LOGO;
  assign alpha_pop = M_AXIS_TVALID_ALPHA && M_AXIS_TREADY_ALPHA;

  // Empty after this edge; lets done rise right after the final pop.
  assign logo_drained  = (logo_cnt == 2'd0) || ((logo_cnt == 2'd1) && logo_pop);
  assign alpha_drained = (alpha_cnt == 2'd0) || ((alpha_cnt == 2'd1) && alpha_pop);

  always_ff @(posedge M_AXI_ACLK) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = zero_size ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && last_pix) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (logo_drained && alpha_drained) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Geometry latch, pixel position and input TLAST checking.
  always_ff @(posedge M_AXI_ACLK) begin
    if (reset) begin
      w_m1        <= '0;
      h_m1        <= '0;
      hcount      <= '0;
      vcount      <= '0;
      done        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      done <= (state_next == ST_DONE);
      if ((state == ST_IDLE) && run) begin
        w_m1        <= logo_width - CW'(1);
        h_m1        <= logo_height - CW'(1);
        hcount      <= '0;
        vcount      <= '0;
        frame_error <= 1'b0;
      end
      if (accept) begin
        if (S_AXIS_TLAST_ARGB != last_pix) begin
          frame_error <= 1'b1;
        end
        if (!last_pix) begin
          if (hcount == w_m1) begin
            hcount <= '0;
            vcount <= vcount + CW'(1);
          end else begin
            hcount <= hcount + CW'(1);
          end
        end
      end
    end
  end

  overlay_v1_0_logo_split_fifo2 #(.W(DW)) u_logo_fifo (
    .clk       (M_AXI_ACLK),
    .reset     (reset),
    .push      (accept),
    .din       (S_AXIS_TDATA_ARGB[DW-1:0]),
    .din_last  (last_pix),
    .pop       (logo_pop),
    .dout      (M_AXIS_TDATA_LOGO),
    .dout_last (M_AXIS_TLAST_LOGO),
    .count     (logo_cnt)
  );

  overlay_v1_0_logo_split_fifo2 #(.W(AW)) u_alpha_fifo (
    .clk       (M_AXI_ACLK),
    .reset     (reset),
    .push      (accept),
    .din       (S_AXIS_TDATA_ARGB[DW+AW-1:DW]),
    .din_last  (last_pix),
    .pop       (alpha_pop),
    .dout      (M_AXIS_TDATA_ALPHA),
    .dout_last (M_AXIS_TLAST_ALPHA),
    .count     (alpha_cnt)
  );

endmodule

// File: doc/overlay_v1_0_logo_split.md
# overlay_v1_0_logo_split

Upstream companion of the overlay data path: accepts one packed logo stream (alpha plus colour per beat) and splits it into the separate logo-colour and alpha AXI-Stream channels the overlay blender consumes. Each output side has its own 2-entry buffer, so one consumer can stall briefly while the other keeps draining. The block counts pixels against the programmed logo geometry and regenerates TLAST from that count. Input TLAST is checked, never forwarded, and a mismatch raises a sticky error.

## Interface
- S_AXI_CTRL_DATA_WIDTH, 32, width of geometry and status words
- DATA_WIDTH, 32, logo colour width; must be a multiple of 8
- ALPHA_WIDTH, 8, alpha width
- M_AXI_ACLK  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- run  in  1  level enable; rising into STREAM starts a logo frame
- logo_width  in  S_AXI_CTRL_DATA_WIDTH  logo pixels per line, latched at frame start
- logo_height  in  S_AXI_CTRL_DATA_WIDTH  logo lines, latched at frame start
- done  out  1  frame fully emitted on both outputs
- frame_error  out  1  sticky input-TLAST mismatch
- hcount, vcount  out  S_AXI_CTRL_DATA_WIDTH each  position of the next pixel to accept
- S_AXIS_TDATA_ARGB  in  DATA_WIDTH+ALPHA_WIDTH  alpha in the MSBs, colour in the low DATA_WIDTH bits
- S_AXIS_TVALID_ARGB / S_AXIS_TREADY_ARGB / S_AXIS_TLAST_ARGB  in/out/in  1  input handshake
- M_AXIS_TDATA_LOGO  out  DATA_WIDTH  colour
- M_AXIS_TVALID_LOGO / M_AXIS_TREADY_LOGO / M_AXIS_TLAST_LOGO  out/in/out  1
- M_AXIS_TDATA_ALPHA  out  ALPHA_WIDTH  alpha
- M_AXIS_TVALID_ALPHA / M_AXIS_TREADY_ALPHA / M_AXIS_TLAST_ALPHA  out/in/out  1

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE to STREAM: when run=1. Latch logo_width and logo_height, zero hcount and vcount, clear frame_error.
- Zero-size frame: if the latched width or height is 0, go IDLE to DONE directly. No beats are accepted.
- S_AXIS_TREADY_ARGB = (state==STREAM) && run && logo buffer count<2 && alpha buffer count<2.
- Accept: on TVALID&&TREADY, write the colour field into the logo buffer and the alpha field into the alpha buffer in the same cycle. Both entries carry last = (hcount==w-1 && vcount==h-1).
- Counter advance: hcount increments per accept. At w-1 it wraps to 0 and vcount increments.
- Last accept: on the last pixel, counters hold and state goes to FLUSH.
- FLUSH to DONE: when both buffers are empty.
- DONE: done=1. When run=0, go to IDLE and done=0.
- run dropped in STREAM: TREADY goes low, counters hold, state stays STREAM, outputs keep draining. Raising run again resumes the same frame with no re-latch.
- TLAST check on every accept: set frame_error if input TLAST≠1 on the last pixel, or TLAST=1 on any other pixel. Counting continues; the output TLASTs always follow the count.
- Output buffers: independent 2-entry FIFOs. TVALID = not empty. Pop on TVALID&&TREADY. Simultaneous push and pop at count 2 is impossible because TREADY is already low. At count 1 or 0, push and pop in the same cycle are both honoured.
- Width rules: the comparisons use the latched w-1 and h-1, computed at S_AXI_CTRL_DATA_WIDTH bits. The zero-size check above guarantees no underflow.
- reset, any cycle including mid-frame: go to IDLE, empty both buffers, zero counters, done=0, frame_error=0. Partially emitted data is discarded.

## Timing
- Reset values: S_AXIS_TREADY_ARGB=0, M_AXIS_TVALID_LOGO=0, M_AXIS_TVALID_ALPHA=0, both TLAST=0, both TDATA=0, done=0, frame_error=0, hcount=vcount=0.
- Latency: a beat accepted at edge N appears on both outputs (TVALID=1) after edge N; there is no combinational input-to-output path.
- Throughput: 1 pixel per cycle when both consumers are always ready.
- Ready path: S_AXIS_TREADY_ARGB depends only on registered state and buffer counts, not on output TREADY. A pop at edge N frees space for acceptance in the cycle after edge N.
- Skew: one output may lead the other by at most 2 beats.
- done timing: done rises the cycle after the later of the two final pops.
- IDLE to STREAM: TREADY can first be high in the cycle after run is sampled high in IDLE.

## Test plan
- Nominal frame: w=4, h=2, 8 beats with input TLAST on beat 7, both consumers always ready.
  - Both outputs carry colour/alpha in order with TLAST on beat 7 only.
  - TREADY is high 8 consecutive cycles; frame_error=0.
  - done rises the cycle after the final pops and falls after run=0.
- Split backpressure: w=3, h=1, M_AXIS_TREADY_ALPHA held 0 for 5 cycles, logo consumer always ready.
  - Logo emits 2 beats, then TREADY_ARGB=0 with the alpha buffer holding 2.
  - After release, all 3 alpha values arrive in order and no data is lost.
- TLAST mismatch: w=4, h=1, input TLAST on beat 1.
  - frame_error=1 from the cycle after beat 1 and stays set.
  - Output TLAST still appears on beat 3 only.
- Zero size: logo_width=0, run=1.
  - done=1 within 2 cycles; TREADY_ARGB never asserts; no output TVALID.
- Pause and reset: w=4, h=2.
  - Drop run after beat 2: TREADY_ARGB=0, hcount=3, vcount=0 held; restore run and the frame completes correctly.
  - Then in a new frame, assert reset after beat 5: next cycle TVALIDs=0, hcount=vcount=0, state IDLE.
